// File: rtl/bucket_histogram.sv
// Per-bucket occurrence histogram fed by one-hot bucket indices, with empty/error
// counters, a registered read port and a sequenced clear sweep.

module bucket_cnt #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 inc,
   input  logic                 zero,
   output logic [CNT_WIDTH-1:0] cnt
);
   // Saturating counter; a zero request wins over an increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  cnt <= '0;
      else if (zero)              cnt <= '0;
      else if (inc && cnt != '1)  cnt <= cnt + CNT_WIDTH'(1);
   end
endmodule

module bucket_histogram #(
   parameter int NUM_BUCKETS = 12,
   parameter int CNT_WIDTH   = 32,
   parameter int ADDR_WIDTH  = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_BUCKETS-1:0] in_index,
   input  logic                   in_valid,
   output logic                   in_rdy,
   input  logic                   clr,
   output logic                   clr_done,
   output logic                   busy,
   input  logic                   rd_req,
   input  logic [ADDR_WIDTH-1:0]  rd_addr,
   output logic                   rd_valid,
   output logic [CNT_WIDTH-1:0]   rd_data
);
   localparam int NC = NUM_BUCKETS + 2;
   localparam int PW = (NUM_BUCKETS > 1) ? $clog2(NUM_BUCKETS) : 1;
   localparam logic [PW-1:0] PTR_LAST = PW'(NUM_BUCKETS - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t                         state, state_nxt;
   logic [PW-1:0]                  ptr;
   logic                           clearing;
   logic                           xfer;
   logic                           s1_vld;
   logic [NUM_BUCKETS-1:0]         s1_idx;
   logic                           multi;
   logic [NC-1:0]                  inc, zero;
   logic [NC-1:0][CNT_WIDTH-1:0]   cnts;
   logic [2**ADDR_WIDTH-1:0][CNT_WIDTH-1:0] rd_mux;

   // FSM: state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (clr)             state_nxt = CLEAR;
         CLEAR:   if (ptr == PTR_LAST) state_nxt = IDLE;
         default:                      state_nxt = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      clearing = (state == CLEAR);
      busy     = clearing;
      in_rdy   = !clearing;
   end

   assign xfer = in_valid && in_rdy;

   // Sweep pointer sits at 0 in IDLE so the first CLEAR cycle targets bucket 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          ptr <= '0;
      else if (!clearing) ptr <= '0;
      else                ptr <= ptr + PW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) clr_done <= 1'b0;
      else       clr_done <= clearing && (ptr == PTR_LAST);
   end

   // Stage 1: a sample accepted alongside clr is flushed before it can count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_vld <= 1'b0;
         s1_idx <= '0;
      end else begin
         s1_vld <= xfer && !clr;
         if (xfer) s1_idx <= in_index;
      end
   end

   // Stage 2: x & (x-1) is non-zero exactly when two or more bits are set.
   assign multi = |(s1_idx & (s1_idx - NUM_BUCKETS'(1)));

   always_comb begin
      inc  = '0;
      zero = '0;
      for (int i = 0; i < NUM_BUCKETS; i++) begin
         inc[i]  = s1_vld && !multi && s1_idx[i];
         zero[i] = clearing && (ptr == PW'(i));
      end
      inc[NUM_BUCKETS]    = s1_vld && (s1_idx == '0);
      inc[NUM_BUCKETS+1]  = s1_vld && multi;
      zero[NUM_BUCKETS]   = clearing && (ptr == '0);
      zero[NUM_BUCKETS+1] = clearing && (ptr == '0);
   end

   for (genvar i = 0; i < NC; i++) begin : g_cnt
      bucket_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
         .clk  (clk),
         .reset(reset),
         .inc  (inc[i]),
         .zero (zero[i]),
         .cnt  (cnts[i])
      );
   end

   // Unmapped addresses read as zero.
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NC; i++) rd_mux[i] = cnts[i];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_req && !clearing;
         if (rd_req && !clearing) rd_data <= rd_mux[rd_addr];
      end
   end
endmodule
